// File: rtl/warp_reg_file_if.sv
// Operand/write-back bundle for warp_reg_file.
// The master side is the issue stage plus load/store unit; the slave side is the register file.
interface warp_reg_file_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 32
);
    localparam int AW = $clog2(NUM_REGS);

    logic                              enable;
    logic [DATA_WIDTH-1:0]             block_id;
    logic [DATA_WIDTH-1:0]             block_size;
    logic [NUM_THREADS-1:0]            thread_mask;
    logic                              wr_en;
    logic [1:0]                        wr_src;
    logic [AW-1:0]                     rd_addr;
    logic [AW-1:0]                     rs1_addr;
    logic [AW-1:0]                     rs2_addr;
    logic [DATA_WIDTH-1:0]             imm;
    logic [NUM_THREADS*DATA_WIDTH-1:0] alu_out;
    logic                              load_issue;
    logic                              load_done;
    logic [AW-1:0]                     load_addr;
    logic [NUM_THREADS-1:0]            load_mask;
    logic [NUM_THREADS*DATA_WIDTH-1:0] lsu_out;
    logic [NUM_THREADS*DATA_WIDTH-1:0] rs1_data;
    logic [NUM_THREADS*DATA_WIDTH-1:0] rs2_data;
    logic                              rd_valid;
    logic                              hazard;
    logic                              err;

    modport master (
        output enable, block_id, block_size, thread_mask, wr_en, wr_src,
               rd_addr, rs1_addr, rs2_addr, imm, alu_out,
               load_issue, load_done, load_addr, load_mask, lsu_out,
        input  rs1_data, rs2_data, rd_valid, hazard, err
    );

    modport slave (
        input  enable, block_id, block_size, thread_mask, wr_en, wr_src,
               rd_addr, rs1_addr, rs2_addr, imm, alu_out,
               load_issue, load_done, load_addr, load_mask, lsu_out,
        output rs1_data, rs2_data, rd_valid, hazard, err
    );
endinterface

// File: rtl/warp_reg_file.sv
// Per-warp SIMT register file: NUM_THREADS lanes, x0-x3 are read-only special registers
// (zero, lane id, block id, block size), x4 and up are stored. One issue write port
// (ALU or immediate), one load write-back port, two registered operand reads, and a
// pending-load scoreboard that raises a combinational hazard flag.
// Optional feature: define WARP_REG_FILE_BYPASS_EN to forward same-cycle write data
// into the operand reads; without it, reads see the pre-write contents.
module warp_reg_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 32
) (
    input  logic           clk,
    input  logic           reset,
    warp_reg_file_if.slave bus
);
    localparam int            AW        = $clog2(NUM_REGS);
    localparam int            VW        = NUM_THREADS * DATA_WIDTH;
    localparam logic [AW-1:0] FIRST_GPR = AW'(4);

`ifdef WARP_REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Only x4..x(NUM_REGS-1) have storage; the reserved registers are synthesised from inputs.
    logic [DATA_WIDTH-1:0] gpr [NUM_THREADS][4:NUM_REGS-1];
    logic [NUM_REGS-1:0]   pending;
    logic [VW-1:0]         rs1_p1;
    logic [VW-1:0]         rs2_p1;
    logic                  vld_p1;
    logic                  err_q;

    logic                  issue_legal;
    logic                  issue_we;
    logic                  load_we;
    logic [VW-1:0]         issue_vec;
    logic [VW-1:0]         rs1_next;
    logic [VW-1:0]         rs2_next;

    // wr_src bit 0 set (01/11) is the illegal encoding; bit 1 selects immediate over ALU.
    assign issue_legal = ~bus.wr_src[0];
    assign issue_we    = bus.enable & bus.wr_en & issue_legal & (bus.rd_addr >= FIRST_GPR);
    assign load_we     = bus.load_done & (bus.load_addr >= FIRST_GPR);

    function automatic logic [DATA_WIDTH-1:0] fixed_value(
        input logic [AW-1:0]         a,
        input int                    lane,
        input logic [DATA_WIDTH-1:0] bid,
        input logic [DATA_WIDTH-1:0] bsize
    );
        case (a[1:0])
            2'd0:    return '0;
            2'd1:    return DATA_WIDTH'(lane);
            2'd2:    return bid;
            default: return bsize;
        endcase
    endfunction

    // Load data outranks issue data when both hit the read address in the same lane.
    function automatic logic [DATA_WIDTH-1:0] read_operand(
        input logic [AW-1:0]         a,
        input int                    lane,
        input logic [DATA_WIDTH-1:0] stored,
        input logic                  load_hit,
        input logic [DATA_WIDTH-1:0] load_val,
        input logic                  issue_hit,
        input logic [DATA_WIDTH-1:0] issue_val
    );
        if (a < FIRST_GPR)           return fixed_value(a, lane, bus.block_id, bus.block_size);
        if (BYPASS && load_hit)      return load_val;
        if (BYPASS && issue_hit)     return issue_val;
        return stored;
    endfunction

    // Per-lane issue write data and the next operand values.
    always_comb begin
        issue_vec = '0;
        rs1_next  = '0;
        rs2_next  = '0;
        for (int l = 0; l < NUM_THREADS; l++) begin
            issue_vec[l*DATA_WIDTH +: DATA_WIDTH] = bus.wr_src[1] ? bus.imm
                                                  : bus.alu_out[l*DATA_WIDTH +: DATA_WIDTH];
            rs1_next[l*DATA_WIDTH +: DATA_WIDTH] = read_operand(
                bus.rs1_addr, l, gpr[l][bus.rs1_addr],
                load_we && bus.load_mask[l] && (bus.load_addr == bus.rs1_addr),
                bus.lsu_out[l*DATA_WIDTH +: DATA_WIDTH],
                issue_we && bus.thread_mask[l] && (bus.rd_addr == bus.rs1_addr),
                issue_vec[l*DATA_WIDTH +: DATA_WIDTH]);
            rs2_next[l*DATA_WIDTH +: DATA_WIDTH] = read_operand(
                bus.rs2_addr, l, gpr[l][bus.rs2_addr],
                load_we && bus.load_mask[l] && (bus.load_addr == bus.rs2_addr),
                bus.lsu_out[l*DATA_WIDTH +: DATA_WIDTH],
                issue_we && bus.thread_mask[l] && (bus.rd_addr == bus.rs2_addr),
                issue_vec[l*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Register storage: issue write first, load write second so overlapping lanes keep load data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int l = 0; l < NUM_THREADS; l++)
                for (int r = 4; r < NUM_REGS; r++)
                    gpr[l][r] <= '0;
        end else begin
            for (int l = 0; l < NUM_THREADS; l++) begin
                if (issue_we && bus.thread_mask[l])
                    gpr[l][bus.rd_addr] <= issue_vec[l*DATA_WIDTH +: DATA_WIDTH];
                if (load_we && bus.load_mask[l])
                    gpr[l][bus.load_addr] <= bus.lsu_out[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scoreboard: completion clears, a same-cycle issue to the same register re-sets it.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (bus.load_done)
                pending[bus.load_addr] <= 1'b0;
            if (bus.enable && bus.load_issue && (bus.rd_addr >= FIRST_GPR))
                pending[bus.rd_addr] <= 1'b1;
        end
    end

    // Stage p1: operand capture on issue, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_p1 <= '0;
            rs2_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.enable;
            if (bus.enable) begin
                rs1_p1 <= rs1_next;
                rs2_p1 <= rs2_next;
            end
        end
    end

    // Sticky flag for an issue write with an illegal source encoding.
    always_ff @(posedge clk) begin
        if (reset)
            err_q <= 1'b0;
        else if (bus.enable && bus.wr_en && !issue_legal)
            err_q <= 1'b1;
    end

    assign bus.rs1_data = rs1_p1;
    assign bus.rs2_data = rs2_p1;
    assign bus.rd_valid = vld_p1;
    assign bus.err      = err_q;
    assign bus.hazard   = pending[bus.rs1_addr] | pending[bus.rs2_addr] | pending[bus.rd_addr];
endmodule

// File: tb/tb_warp_reg_file.sv
// Testbench for warp_reg_file: directed scenarios plus a randomized run against a
// behavioural register-file model held in plain arrays.
module tb_warp_reg_file;
    localparam int DW = 32;
    localparam int NT = 4;
    localparam int NR = 32;
    localparam int AW = $clog2(NR);

`ifdef WARP_REG_FILE_BYPASS_EN
    localparam bit TB_BYPASS = 1'b1;
`else
    localparam bit TB_BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    warp_reg_file_if #(.DATA_WIDTH(DW), .NUM_THREADS(NT), .NUM_REGS(NR)) bif ();

    warp_reg_file #(.DATA_WIDTH(DW), .NUM_THREADS(NT), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [DW-1:0] m_reg  [NR][NT];
    logic          m_pend [NR];
    logic          m_err;
    logic          m_vld;
    logic [DW-1:0] m_rs1  [NT];
    logic [DW-1:0] m_rs2  [NT];

    function automatic logic [DW-1:0] exp_read(input int a, input int l);
        logic [DW-1:0] v;
        if (a == 0) return '0;
        if (a == 1) return DW'(l);
        if (a == 2) return bif.block_id;
        if (a == 3) return bif.block_size;
        v = m_reg[a][l];
        if (TB_BYPASS) begin
            if (bif.enable && bif.wr_en && !bif.wr_src[0] && bif.thread_mask[l]
                && int'(bif.rd_addr) == a)
                v = bif.wr_src[1] ? bif.imm : bif.alu_out[l*DW +: DW];
            if (bif.load_done && bif.load_mask[l] && int'(bif.load_addr) == a)
                v = bif.lsu_out[l*DW +: DW];
        end
        return v;
    endfunction

    function automatic logic exp_hazard();
        return m_pend[bif.rs1_addr] | m_pend[bif.rs2_addr] | m_pend[bif.rd_addr];
    endfunction

    task automatic drive_idle();
        bif.enable = 0; bif.block_id = '0; bif.block_size = '0; bif.thread_mask = '0;
        bif.wr_en = 0; bif.wr_src = 2'b00; bif.rd_addr = '0; bif.rs1_addr = '0;
        bif.rs2_addr = '0; bif.imm = '0; bif.alu_out = '0; bif.load_issue = 0;
        bif.load_done = 0; bif.load_addr = '0; bif.load_mask = '0; bif.lsu_out = '0;
    endtask

    // Advance one clock and move the model forward with the inputs seen at that edge.
    task automatic tick();
        logic [DW-1:0] n_rs1 [NT];
        logic [DW-1:0] n_rs2 [NT];
        int            rd, la;
        for (int l = 0; l < NT; l++) begin
            n_rs1[l] = exp_read(int'(bif.rs1_addr), l);
            n_rs2[l] = exp_read(int'(bif.rs2_addr), l);
        end
        @(posedge clk);
        rd = int'(bif.rd_addr);
        la = int'(bif.load_addr);
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                m_pend[r] = 1'b0;
                for (int l = 0; l < NT; l++) m_reg[r][l] = '0;
            end
            for (int l = 0; l < NT; l++) begin m_rs1[l] = '0; m_rs2[l] = '0; end
            m_err = 1'b0;
            m_vld = 1'b0;
        end else begin
            if (bif.enable && bif.wr_en && (bif.wr_src == 2'b01 || bif.wr_src == 2'b11))
                m_err = 1'b1;
            for (int l = 0; l < NT; l++) begin
                if (bif.enable && bif.wr_en && (bif.wr_src == 2'b00 || bif.wr_src == 2'b10)
                    && bif.thread_mask[l] && rd >= 4)
                    m_reg[rd][l] = (bif.wr_src == 2'b10) ? bif.imm : bif.alu_out[l*DW +: DW];
                if (bif.load_done && bif.load_mask[l] && la >= 4)
                    m_reg[la][l] = bif.lsu_out[l*DW +: DW];
            end
            if (bif.load_done) m_pend[la] = 1'b0;
            if (bif.enable && bif.load_issue && rd >= 4) m_pend[rd] = 1'b1;
            m_vld = bif.enable;
            if (bif.enable)
                for (int l = 0; l < NT; l++) begin m_rs1[l] = n_rs1[l]; m_rs2[l] = n_rs2[l]; end
        end
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        bif.enable = 1; bif.load_issue = 1; bif.rd_addr = AW'(10);
        bif.load_done = 1; bif.load_addr = AW'(12); bif.load_mask = '1; bif.lsu_out = '1;
        tick();
        tick();
        reset = 1'b0;
        drive_idle();
        bif.rs1_addr = AW'(10);
        #1;
        checks++; if (bif.rs1_data !== '0) begin failures++;
            $display("FAIL reset_rs1 got=%h exp=0", bif.rs1_data); end
        checks++; if (bif.rs2_data !== '0) begin failures++;
            $display("FAIL reset_rs2 got=%h exp=0", bif.rs2_data); end
        checks++; if (bif.rd_valid !== 1'b0) begin failures++;
            $display("FAIL reset_rd_valid got=%b exp=0", bif.rd_valid); end
        checks++; if (bif.err !== 1'b0) begin failures++;
            $display("FAIL reset_err got=%b exp=0", bif.err); end
        checks++; if (bif.hazard !== 1'b0) begin failures++;
            $display("FAIL reset_hazard got=%b exp=0", bif.hazard); end
    endtask

    task automatic test_special_regs();
        logic [DW-1:0] got;
        drive_idle();
        bif.block_id = 32'd7; bif.block_size = 32'd64;
        bif.enable = 1; bif.rs1_addr = AW'(1); bif.rs2_addr = AW'(2);
        tick();
        checks++; if (bif.rd_valid !== 1'b1) begin failures++;
            $display("FAIL special_rd_valid got=%b exp=1", bif.rd_valid); end
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            checks++; if (got !== DW'(l)) begin failures++;
                $display("FAIL special_x1 lane%0d got=%h exp=%h", l, got, DW'(l)); end
            got = bif.rs2_data[l*DW +: DW];
            checks++; if (got !== 32'd7) begin failures++;
                $display("FAIL special_x2 lane%0d got=%h exp=7", l, got); end
        end
        bif.rs1_addr = AW'(3); bif.rs2_addr = AW'(0);
        tick();
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            checks++; if (got !== 32'd64) begin failures++;
                $display("FAIL special_x3 lane%0d got=%h exp=40", l, got); end
            got = bif.rs2_data[l*DW +: DW];
            checks++; if (got !== 32'd0) begin failures++;
                $display("FAIL special_x0 lane%0d got=%h exp=0", l, got); end
        end
        bif.enable = 0; bif.rs1_addr = AW'(1);
        tick();
        checks++; if (bif.rd_valid !== 1'b0) begin failures++;
            $display("FAIL hold_rd_valid got=%b exp=0", bif.rd_valid); end
        got = bif.rs1_data[DW +: DW];
        checks++; if (got !== 32'd64) begin failures++;
            $display("FAIL hold_rs1 got=%h exp=40", got); end
    endtask

    task automatic test_imm_write_mask();
        logic [DW-1:0] got, exp;
        drive_idle();
        bif.enable = 1; bif.wr_en = 1; bif.wr_src = 2'b10; bif.imm = 32'hABCD;
        bif.rd_addr = AW'(5); bif.thread_mask = 4'b0101;
        bif.alu_out = {4{32'h1111_1111}};
        tick();
        drive_idle();
        bif.enable = 1; bif.rs1_addr = AW'(5);
        tick();
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            exp = (l % 2 == 0) ? 32'hABCD : 32'h0;
            checks++; if (got !== exp) begin failures++;
                $display("FAIL imm_mask lane%0d got=%h exp=%h", l, got, exp); end
        end
    endtask

    task automatic test_load_hazard();
        logic [DW-1:0] got;
        drive_idle();
        bif.enable = 1; bif.load_issue = 1; bif.rd_addr = AW'(8);
        tick();
        drive_idle();
        bif.rs1_addr = AW'(8);
        #1;
        checks++; if (bif.hazard !== 1'b1) begin failures++;
            $display("FAIL hazard_rs1 got=%b exp=1", bif.hazard); end
        bif.rs1_addr = '0; bif.rs2_addr = AW'(8);
        #1;
        checks++; if (bif.hazard !== 1'b1) begin failures++;
            $display("FAIL hazard_rs2 got=%b exp=1", bif.hazard); end
        bif.rs2_addr = '0; bif.rd_addr = AW'(8);
        #1;
        checks++; if (bif.hazard !== 1'b1) begin failures++;
            $display("FAIL hazard_rd got=%b exp=1", bif.hazard); end
        bif.rd_addr = AW'(9);
        #1;
        checks++; if (bif.hazard !== 1'b0) begin failures++;
            $display("FAIL hazard_other got=%b exp=0", bif.hazard); end
        bif.rd_addr = '0;
        bif.load_done = 1; bif.load_addr = AW'(8); bif.load_mask = 4'b1111;
        bif.lsu_out = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        drive_idle();
        bif.rs1_addr = AW'(8);
        #1;
        checks++; if (bif.hazard !== 1'b0) begin failures++;
            $display("FAIL hazard_cleared got=%b exp=0", bif.hazard); end
        bif.enable = 1;
        tick();
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            checks++; if (got !== DW'(l + 1)) begin failures++;
                $display("FAIL load_data lane%0d got=%h exp=%h", l, got, DW'(l + 1)); end
        end
        // Issue and completion to the same register in one cycle: issue wins.
        drive_idle();
        bif.enable = 1; bif.load_issue = 1; bif.rd_addr = AW'(9);
        bif.load_done = 1; bif.load_addr = AW'(9);
        tick();
        drive_idle();
        bif.rs1_addr = AW'(9);
        #1;
        checks++; if (bif.hazard !== 1'b1) begin failures++;
            $display("FAIL issue_wins got=%b exp=1", bif.hazard); end
        bif.load_done = 1; bif.load_addr = AW'(9);
        tick();
        bif.load_done = 0;
        #1;
        checks++; if (bif.hazard !== 1'b0) begin failures++;
            $display("FAIL issue_wins_clear got=%b exp=0", bif.hazard); end
    endtask

    task automatic test_x0_write();
        drive_idle();
        bif.enable = 1; bif.wr_en = 1; bif.wr_src = 2'b00; bif.rd_addr = '0;
        bif.thread_mask = '1; bif.alu_out = {4{32'd5}};
        tick();
        drive_idle();
        bif.enable = 1; bif.rs1_addr = '0;
        tick();
        checks++; if (bif.rs1_data !== '0) begin failures++;
            $display("FAIL x0_write got=%h exp=0", bif.rs1_data); end
        checks++; if (bif.err !== 1'b0) begin failures++;
            $display("FAIL x0_err got=%b exp=0", bif.err); end
    endtask

    task automatic test_err_sticky();
        drive_idle();
        bif.enable = 1; bif.wr_en = 1; bif.wr_src = 2'b11; bif.rd_addr = AW'(6);
        bif.thread_mask = '1; bif.alu_out = {4{32'h55}}; bif.imm = 32'h66;
        tick();
        checks++; if (bif.err !== 1'b1) begin failures++;
            $display("FAIL err_set got=%b exp=1", bif.err); end
        drive_idle();
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bif.err !== 1'b1) begin failures++;
            $display("FAIL err_sticky got=%b exp=1", bif.err); end
        bif.enable = 1; bif.rs1_addr = AW'(6);
        tick();
        checks++; if (bif.rs1_data !== '0) begin failures++;
            $display("FAIL err_nowrite got=%h exp=0", bif.rs1_data); end
        reset = 1'b1; drive_idle(); tick(); reset = 1'b0;
        checks++; if (bif.err !== 1'b0) begin failures++;
            $display("FAIL err_reset got=%b exp=0", bif.err); end
        bif.enable = 1; bif.wr_en = 1; bif.wr_src = 2'b01; bif.rd_addr = AW'(6);
        tick();
        checks++; if (bif.err !== 1'b1) begin failures++;
            $display("FAIL err_01 got=%b exp=1", bif.err); end
        reset = 1'b1; drive_idle(); tick(); reset = 1'b0;
    endtask

    task automatic test_bypass();
        logic [DW-1:0] got, exp;
        logic [DW-1:0] ovl [NT];
        ovl[0] = 32'h11; ovl[1] = 32'h22; ovl[2] = 32'h22; ovl[3] = 32'h0;
        drive_idle();
        bif.enable = 1; bif.wr_en = 1; bif.wr_src = 2'b00; bif.rd_addr = AW'(6);
        bif.thread_mask = '1; bif.alu_out = {4{32'd9}}; bif.rs1_addr = AW'(6);
        tick();
        exp = TB_BYPASS ? 32'd9 : 32'd0;
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            checks++; if (got !== exp) begin failures++;
                $display("FAIL bypass_x6 lane%0d got=%h exp=%h", l, got, exp); end
        end
        // Issue (lanes 0,1) and load (lanes 1,2) to x7 together; load owns lane 1.
        drive_idle();
        bif.enable = 1; bif.wr_en = 1; bif.wr_src = 2'b10; bif.imm = 32'h11;
        bif.rd_addr = AW'(7); bif.thread_mask = 4'b0011;
        bif.load_done = 1; bif.load_addr = AW'(7); bif.load_mask = 4'b0110;
        bif.lsu_out = {4{32'h22}};
        bif.rs1_addr = AW'(7); bif.rs2_addr = AW'(6);
        tick();
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            exp = TB_BYPASS ? ovl[l] : 32'h0;
            checks++; if (got !== exp) begin failures++;
                $display("FAIL bypass_merge lane%0d got=%h exp=%h", l, got, exp); end
            got = bif.rs2_data[l*DW +: DW];
            checks++; if (got !== 32'd9) begin failures++;
                $display("FAIL stored_x6 lane%0d got=%h exp=9", l, got); end
        end
        drive_idle();
        bif.enable = 1; bif.rs1_addr = AW'(7);
        tick();
        for (int l = 0; l < NT; l++) begin
            got = bif.rs1_data[l*DW +: DW];
            checks++; if (got !== ovl[l]) begin failures++;
                $display("FAIL merge_stored lane%0d got=%h exp=%h", l, got, ovl[l]); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] got;
        for (int cyc = 0; cyc < 400; cyc++) begin
            reset = ($urandom_range(0, 63) == 0);
            bif.enable      = ($urandom_range(0, 3) != 0);
            bif.block_id    = $urandom;
            bif.block_size  = $urandom;
            bif.thread_mask = NT'($urandom);
            bif.wr_en       = $urandom_range(0, 1);
            bif.wr_src      = ($urandom_range(0, 15) == 0) ? 2'(1 + 2 * $urandom_range(0, 1))
                                                           : 2'(2 * $urandom_range(0, 1));
            bif.rd_addr     = AW'($urandom_range(0, 15));
            bif.rs1_addr    = AW'($urandom_range(0, 15));
            bif.rs2_addr    = AW'($urandom_range(0, 15));
            bif.imm         = $urandom;
            for (int l = 0; l < NT; l++) begin
                bif.alu_out[l*DW +: DW] = $urandom;
                bif.lsu_out[l*DW +: DW] = $urandom;
            end
            bif.load_issue  = ($urandom_range(0, 3) == 0);
            bif.load_done   = ($urandom_range(0, 3) == 0);
            bif.load_addr   = AW'($urandom_range(0, 15));
            bif.load_mask   = NT'($urandom);
            #1;
            checks++; if (bif.hazard !== exp_hazard()) begin failures++;
                $display("FAIL rand_hazard cyc%0d got=%b exp=%b", cyc, bif.hazard, exp_hazard()); end
            tick();
            checks++; if (bif.rd_valid !== m_vld) begin failures++;
                $display("FAIL rand_rd_valid cyc%0d got=%b exp=%b", cyc, bif.rd_valid, m_vld); end
            checks++; if (bif.err !== m_err) begin failures++;
                $display("FAIL rand_err cyc%0d got=%b exp=%b", cyc, bif.err, m_err); end
            for (int l = 0; l < NT; l++) begin
                got = bif.rs1_data[l*DW +: DW];
                checks++; if (got !== m_rs1[l]) begin failures++;
                    $display("FAIL rand_rs1 cyc%0d lane%0d got=%h exp=%h", cyc, l, got, m_rs1[l]); end
                got = bif.rs2_data[l*DW +: DW];
                checks++; if (got !== m_rs2[l]) begin failures++;
                    $display("FAIL rand_rs2 cyc%0d lane%0d got=%h exp=%h", cyc, l, got, m_rs2[l]); end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_special_regs();
        test_imm_write_mask();
        test_load_hazard();
        test_x0_write();
        test_err_sticky();
        test_bypass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
